cross_bar_slave_mem: RTL and testbench
======================================

CROSS_BAR_SLAVE_MEM -- requirements
Module: cross_bar_slave_mem

Interface
REQ-001 SHALL provide parameter DEPTH_W, default 8: memory holds 2**DEPTH_W words of DATA_W bits.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2: extra wait states per access; legal range 0..15.
REQ-003 SHALL take ADDR_W and DATA_W from cross_bar_pkg; addr_t and data_t are the package types.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 aresetn  input  1  asynchronous active-low reset.
REQ-007 req  input  1  request from the crossbar slave port; held high until ack is sampled.
REQ-008 addr  input  ADDR_W  byte address; stable while req=1.
REQ-009 cmd  input  1  1=write, 0=read; stable while req=1.
REQ-010 wdata  input  DATA_W  write data; stable while req=1.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  read data; valid in the ack cycle of a read.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK; encoding free.
REQ-015 IDLE: req=1 at an edge -> capture addr/cmd/wdata; go to ACK if WAIT_CYCLES=0, else load wait counter with WAIT_CYCLES and go to WAIT.
REQ-016 IDLE: req=0 -> stay IDLE; no memory access.
REQ-017 WAIT: decrement counter each edge; on the edge where counter=1, go to ACK; req/addr changes during WAIT are ignored (captured values used).
REQ-018 ACK: ack=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-019 Latency: req first high in cycle N (FSM in IDLE) -> ack high in cycle N+WAIT_CYCLES+1, exactly.
REQ-020 Memory word index = captured addr[DEPTH_W+1:2]; addr[1:0] and bits above DEPTH_W+1 ignored (aliasing is legal).
REQ-021 Write: on the edge entering ACK, mem[index] <= captured wdata; rdata unchanged.
REQ-022 Read: on the edge entering ACK, rdata <= mem[index]; rdata holds that value until the next read.
REQ-023 Back-to-back: req still high in the cycle after ack is a new request, accepted in the IDLE cycle following ACK; minimum spacing between acks is WAIT_CYCLES+2 cycles.
REQ-024 Read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-025 ack SHALL never be asserted in two consecutive cycles.
REQ-026 ack and busy SHALL be registered outputs with no combinational path from inputs.
REQ-027 Memory contents SHALL NOT be reset; reads of never-written words return undefined data.

Reset
REQ-028 aresetn=0 SHALL immediately force ack=0, busy=0, rdata=0, wait counter=0, FSM=IDLE.
REQ-029 Reset mid-transaction (WAIT or ACK) SHALL discard the captured request; a write not yet in ACK SHALL NOT modify memory.
REQ-030 First request SHALL be accepted at the first rising edge after aresetn deasserts with req=1.

Verification
REQ-031 WAIT_CYCLES=2: write addr 0x10, wdata 0xDEADBEEF, req high cycle 0 -> ack high in cycle 3 only; then read addr 0x10 -> ack 3 cycles after acceptance, rdata=0xDEADBEEF.
REQ-032 WAIT_CYCLES=0: req held high for 4 reads of pre-written words 0x0,0x4,0x8,0xC -> acks in cycles 1,3,5,7 with matching data, never two consecutive.
REQ-033 Aliasing, DEPTH_W=8: write 0x1234 to addr 0x404 -> read addr 0x004 returns 0x1234; addr 0x007 also returns 0x1234.
REQ-034 Reset during WAIT of a write of 0xAAAA to addr 0x20 (prior value 0x5555) -> ack stays 0, busy=0, rdata=0; subsequent read of 0x20 returns 0x5555.
REQ-035 Inputs changed during WAIT (addr 0x40->0x80, wdata changed) -> write lands at 0x40 with originally captured data.
REQ-036 WAIT_CYCLES=15: single read -> ack exactly 16 cycles after acceptance; busy high for cycles 1..16.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared crossbar widths and the address/data types used by every crossbar port.
package cross_bar_pkg;
  parameter int unsigned ADDR_W = 32;
  parameter int unsigned DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/cross_bar_slave_mem.sv
// Word-addressed memory slave for the crossbar: one request at a time, WAIT_CYCLES
// wait states, then a single-cycle ack with read data held until the next read.
module cross_bar_slave_mem
  import cross_bar_pkg::*;
#(
  parameter int unsigned DEPTH_W     = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  aresetn,
  input  logic  req,
  input  addr_t addr,
  input  logic  cmd,
  input  data_t wdata,
  output logic  ack,
  output data_t rdata,
  output logic  busy
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  addr_t       addr_q;
  logic        cmd_q;
  data_t       wdata_q;
  data_t       rdata_q;
  logic        ack_q, busy_q;

  addr_t              acc_addr;
  logic               acc_cmd;
  data_t              acc_wdata;
  logic [DEPTH_W-1:0] idx;
  logic               enter_ack;
  logic               unused_addr;

  data_t mem_q [2**DEPTH_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StAck;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  always_comb begin
    acc_addr  = (state_q == StIdle) ? addr  : addr_q;
    acc_cmd   = (state_q == StIdle) ? cmd   : cmd_q;
    acc_wdata = (state_q == StIdle) ? wdata : wdata_q;
  end

  assign idx         = acc_addr[DEPTH_W+1:2];
  assign unused_addr = ^{acc_addr[1:0], acc_addr[ADDR_W-1:DEPTH_W+2]};
  // Gating with aresetn keeps a write from landing while reset is held.
  assign enter_ack   = (state_d == StAck) && (state_q != StAck) && aresetn;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == StAck);
      busy_q  <= (state_d != StIdle);
      if (state_q == StIdle && req) begin
        addr_q  <= addr;
        cmd_q   <= cmd;
        wdata_q <= wdata;
      end
      if (enter_ack && !acc_cmd) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enter_ack && acc_cmd) begin
      mem_q[idx] <= acc_wdata;
    end
  end

  assign ack   = ack_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Directed bench for cross_bar_slave_mem: three instances with 0, 2 and 15 wait states
// sharing clock and reset, each driven by its own request signals.
module tb_cross_bar_slave_mem;
  import cross_bar_pkg::*;

  logic clk, aresetn;
  logic req0, cmd0, ack0, busy0;
  logic req2, cmd2, ack2, busy2;
  logic req15, cmd15, ack15, busy15;
  addr_t addr0, addr2, addr15;
  data_t wdata0, wdata2, wdata15, rdata0, rdata2, rdata15;

  int errors = 0;
  int checks = 0;

  cross_bar_slave_mem #(.DEPTH_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .aresetn(aresetn), .req(req0), .addr(addr0), .cmd(cmd0),
    .wdata(wdata0), .ack(ack0), .rdata(rdata0), .busy(busy0)
  );
  cross_bar_slave_mem #(.DEPTH_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .aresetn(aresetn), .req(req2), .addr(addr2), .cmd(cmd2),
    .wdata(wdata2), .ack(ack2), .rdata(rdata2), .busy(busy2)
  );
  cross_bar_slave_mem #(.DEPTH_W(8), .WAIT_CYCLES(15)) u_dut15 (
    .clk(clk), .aresetn(aresetn), .req(req15), .addr(addr15), .cmd(cmd15),
    .wdata(wdata15), .ack(ack15), .rdata(rdata15), .busy(busy15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle starts just after the rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic r, input logic c, input addr_t a,
                       input data_t d);
    case (sel)
      0:       begin req0 = r;  cmd0 = c;  addr0 = a;  wdata0 = d;  end
      2:       begin req2 = r;  cmd2 = c;  addr2 = a;  wdata2 = d;  end
      default: begin req15 = r; cmd15 = c; addr15 = a; wdata15 = d; end
    endcase
  endtask

  function automatic logic get_ack(input int sel);
    case (sel)
      0:       return ack0;
      2:       return ack2;
      default: return ack15;
    endcase
  endfunction

  function automatic data_t get_rdata(input int sel);
    case (sel)
      0:       return rdata0;
      2:       return rdata2;
      default: return rdata15;
    endcase
  endfunction

  // Issues one request and returns the ack latency (-1 on timeout) and rdata seen with ack.
  task automatic xact(input int sel, input logic c, input addr_t a, input data_t d,
                      output data_t rd, output int lat);
    drive(sel, 1'b1, c, a, d);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (get_ack(sel) === 1'b1) begin
        lat = i;
        break;
      end
    end
    rd = get_rdata(sel);
    drive(sel, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    drive(15, 1'b0, 1'b0, '0, '0);
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({ack0, busy0, ack2, busy2, ack15, busy15} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack/busy got %b required 000000",
               {ack0, busy0, ack2, busy2, ack15, busy15});
    end
    checks++;
    if (rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 00000000", rdata2);
    end
    tick();
    tick();
    checks++;
    if ({ack2, busy2, rdata0} !== 34'h0) begin
      errors++;
      $display("FAIL reset_held: got %h required 0", {ack2, busy2, rdata0});
    end
    aresetn = 1'b1;
  endtask

  task automatic test_write_read();
    data_t rd;
    int lat;
    // Request is raised in the same cycle reset deasserts: first edge must accept it.
    drive(2, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    checks++;
    if (ack2 !== 1'b0) begin
      errors++;
      $display("FAIL wr_cycle0_ack: got %b required 0", ack2);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (ack2 !== (c == 3) || busy2 !== (c <= 3)) begin
        errors++;
        $display("FAIL wr_cycle%0d: ack=%b busy=%b required ack=%b busy=%b",
                 c, ack2, busy2, c == 3, c <= 3);
      end
      if (c == 3) begin
        drive(2, 1'b0, 1'b0, '0, '0);
        checks++;
        if (rdata2 !== 32'h0) begin
          errors++;
          $display("FAIL wr_rdata_unchanged: got %h required 00000000", rdata2);
        end
      end
    end
    xact(2, 1'b0, 32'h10, '0, rd, lat);
    checks++;
    if (lat !== 3 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_after_wr: lat=%0d data=%h required lat=3 data=deadbeef", lat, rd);
    end
  endtask

  task automatic test_alias();
    data_t rd;
    int lat;
    xact(2, 1'b1, 32'h404, 32'h1234, rd, lat);
    xact(2, 1'b0, 32'h004, '0, rd, lat);
    checks++;
    if (rd !== 32'h1234) begin
      errors++;
      $display("FAIL alias_004: got %h required 00001234", rd);
    end
    xact(2, 1'b0, 32'h007, '0, rd, lat);
    checks++;
    if (rd !== 32'h1234) begin
      errors++;
      $display("FAIL alias_007: got %h required 00001234", rd);
    end
  endtask

  task automatic test_wait_inputs();
    data_t rd;
    int lat;
    xact(2, 1'b1, 32'h80, 32'h33333333, rd, lat);
    drive(2, 1'b1, 1'b1, 32'h40, 32'h11111111);
    tick();
    drive(2, 1'b0, 1'b1, 32'h80, 32'h22222222);
    tick();
    drive(2, 1'b1, 1'b0, 32'h80, 32'h22222222);
    tick();
    checks++;
    if (ack2 !== 1'b1) begin
      errors++;
      $display("FAIL wait_inputs_ack: got %b required 1", ack2);
    end
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    xact(2, 1'b0, 32'h40, '0, rd, lat);
    checks++;
    if (rd !== 32'h11111111) begin
      errors++;
      $display("FAIL wait_inputs_40: got %h required 11111111", rd);
    end
    xact(2, 1'b0, 32'h80, '0, rd, lat);
    checks++;
    if (rd !== 32'h33333333) begin
      errors++;
      $display("FAIL wait_inputs_80: got %h required 33333333", rd);
    end
  endtask

  task automatic test_reset_mid();
    data_t rd;
    int lat;
    xact(2, 1'b1, 32'h20, 32'h5555, rd, lat);
    xact(2, 1'b0, 32'h04, '0, rd, lat);
    drive(2, 1'b1, 1'b1, 32'h20, 32'hAAAA);
    tick();
    aresetn = 1'b0;
    #1;
    checks++;
    if ({ack2, busy2} !== 2'b00 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: ack=%b busy=%b rdata=%h required 0 0 00000000",
               ack2, busy2, rdata2);
    end
    tick();
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (ack2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_noack: got %b required 0", ack2);
    end
    aresetn = 1'b1;
    tick();
    xact(2, 1'b0, 32'h20, '0, rd, lat);
    checks++;
    if (rd !== 32'h5555) begin
      errors++;
      $display("FAIL reset_mid_mem: got %h required 00005555", rd);
    end
  endtask

  task automatic test_back_to_back();
    data_t rd;
    data_t vals [4];
    int lat;
    int k;
    for (int i = 0; i < 4; i++) begin
      vals[i] = 32'hA0A00000 + 32'(i);
      xact(0, 1'b1, addr_t'(i * 4), vals[i], rd, lat);
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("FAIL b2b_prewrite_lat%0d: got %0d required 1", i, lat);
      end
    end
    k = 0;
    drive(0, 1'b1, 1'b0, 32'h0, '0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (ack0 !== (c % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_ack_cycle%0d: got %b required %b", c, ack0, c % 2 == 1);
      end
      if (ack0 === 1'b1 && k < 4) begin
        checks++;
        if (rdata0 !== vals[k]) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h required %h", k, rdata0, vals[k]);
        end
        k++;
        if (k < 4) addr0 = addr_t'(k * 4);
        else req0 = 1'b0;
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_long_wait();
    data_t rd;
    int lat;
    xact(15, 1'b1, 32'h8, 32'hC0FFEE00, rd, lat);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL long_write_lat: got %0d required 16", lat);
    end
    drive(15, 1'b1, 1'b0, 32'h8, '0);
    for (int c = 1; c <= 18; c++) begin
      tick();
      checks++;
      if (ack15 !== (c == 16) || busy15 !== (c <= 16)) begin
        errors++;
        $display("FAIL long_cycle%0d: ack=%b busy=%b required ack=%b busy=%b",
                 c, ack15, busy15, c == 16, c <= 16);
      end
      if (c == 16) begin
        checks++;
        if (rdata15 !== 32'hC0FFEE00) begin
          errors++;
          $display("FAIL long_rdata: got %h required c0ffee00", rdata15);
        end
        drive(15, 1'b0, 1'b0, '0, '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_wait_inputs();
    test_reset_mid();
    test_back_to_back();
    test_long_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
